video_pattern_gen: RTL

Parametrised raster test-pattern generator: successor to the single-bit bouncing-square generator. Produces a full raster timing (DE, HSYNC, VSYNC, start-of-frame) plus a multi-bit RGB pixel from one of four runtime-selectable patterns. It sits between the pixel-clock enable source and the video output serialiser/encoder. All outputs are registered, with a one-pixel pipeline latency after the raster counters.

---
 rtl/video_pattern_gen_if.sv | 15 +
 rtl/video_pattern_gen.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/video_pattern_gen_if.sv
// Pixel-rate control inputs and registered raster/pixel outputs of the test-pattern generator.
interface video_pattern_gen_if #(
    parameter int PixWidth = 3
);
    logic                ce_i;
    logic [1:0]          mode_i;
    logic                de_o;
    logic                hsync_o;
    logic                vsync_o;
    logic                sof_o;
    logic [PixWidth-1:0] pix_o;

    modport master (output ce_i, mode_i, input de_o, hsync_o, vsync_o, sof_o, pix_o);
    modport slave  (input ce_i, mode_i, output de_o, hsync_o, vsync_o, sof_o, pix_o);
endinterface

// File: rtl/video_pattern_gen.sv
// Raster timing generator with four selectable test patterns (bouncing sprite, colour bars,
// checkerboard, grid); every output is registered one enabled pixel after the raster counters.
module video_pattern_gen #(
    parameter int   ColActive  = 640,
    parameter int   ColFront   = 16,
    parameter int   ColSync    = 96,
    parameter int   ColBack    = 48,
    parameter int   RowActive  = 480,
    parameter int   RowFront   = 10,
    parameter int   RowSync    = 2,
    parameter int   RowBack    = 33,
    parameter logic SyncActive = 1'b0,
    parameter int   PixWidth   = 3,
    parameter int   SquareSize = 32,
    parameter int   SquareStep = 1,
    parameter int   CheckLog2  = 4
) (
    input  logic               clk_i,
    input  logic               rst_i,
    video_pattern_gen_if.slave vid
);
    localparam int CntW     = 12;
    localparam int ColTotal = ColActive + ColFront + ColSync + ColBack;
    localparam int RowTotal = RowActive + RowFront + RowSync + RowBack;
    localparam int BarW     = ColActive / 8;

    typedef logic [CntW-1:0] cnt_t;

    localparam cnt_t ColLast    = cnt_t'(ColTotal - 1);
    localparam cnt_t RowLast    = cnt_t'(RowTotal - 1);
    localparam cnt_t ColAct     = cnt_t'(ColActive);
    localparam cnt_t RowAct     = cnt_t'(RowActive);
    localparam cnt_t ColActLast = cnt_t'(ColActive - 1);
    localparam cnt_t RowActLast = cnt_t'(RowActive - 1);
    localparam cnt_t HsBeg      = cnt_t'(ColActive + ColFront);
    localparam cnt_t HsEnd      = cnt_t'(ColActive + ColFront + ColSync);
    localparam cnt_t VsBeg      = cnt_t'(RowActive + RowFront);
    localparam cnt_t VsEnd      = cnt_t'(RowActive + RowFront + RowSync);
    localparam cnt_t XMax       = cnt_t'(ColActive - SquareSize);
    localparam cnt_t YMax       = cnt_t'(RowActive - SquareSize);
    localparam cnt_t Step       = cnt_t'(SquareStep);
    localparam cnt_t Size       = cnt_t'(SquareSize);
    localparam cnt_t BarLast    = cnt_t'(BarW - 1);

    // One frame of sprite motion on one axis; returns {dir, pos}, clamping at both walls.
    function automatic logic [CntW:0] bounce(input cnt_t pos, input logic dir, input cnt_t lim);
        logic [CntW:0] fwd;
        fwd = {1'b0, pos} + {1'b0, Step};
        if (!dir) begin
            if (fwd >= {1'b0, lim}) bounce = {1'b1, lim};
            else                    bounce = {1'b0, fwd[CntW-1:0]};
        end else begin
            if (pos <= Step) bounce = {1'b0, cnt_t'(0)};
            else             bounce = {1'b1, pos - Step};
        end
    endfunction

    cnt_t                col_q, col_d, row_q, row_d;
    cnt_t                bar_cnt_q, bar_cnt_d;
    logic [2:0]          bar_idx_q, bar_idx_d;
    cnt_t                sx_q, sx_d, sy_q, sy_d;
    logic                dx_q, dx_d, dy_q, dy_d;
    logic [1:0]          mode_q, mode_d;
    logic                de_q, de_d, hs_q, hs_d, vs_q, vs_d, sof_q, sof_d;
    logic [PixWidth-1:0] pix_q, pix_d;

    logic                col_wrap, frame_end, active, in_sprite;
    logic [2:0]          rgb;
    logic [PixWidth-1:0] pix_rgb;

    always_comb begin
        col_wrap  = (col_q == ColLast);
        frame_end = col_wrap && (row_q == RowLast);
        active    = (col_q < ColAct) && (row_q < RowAct);
        in_sprite = (col_q >= sx_q) && ({1'b0, col_q} < ({1'b0, sx_q} + {1'b0, Size})) &&
                    (row_q >= sy_q) && ({1'b0, row_q} < ({1'b0, sy_q} + {1'b0, Size}));
        rgb = '0;
        case (mode_q)
            2'd0: rgb = {3{in_sprite}};
            2'd1: rgb = 3'd7 - bar_idx_q;
            2'd2: rgb = {3{col_q[CheckLog2] ^ row_q[CheckLog2]}};
            default: rgb = {3{(col_q[4:0] == 5'd0) || (row_q[4:0] == 5'd0) ||
                              (col_q == ColActLast) || (row_q == RowActLast)}};
        endcase
    end

    // Wider pixels repeat the R/G/B bits cyclically above bit 2.
    for (genvar g = 0; g < PixWidth; g++) begin : g_pix
        assign pix_rgb[g] = rgb[g % 3];
    end

    always_comb begin
        col_d     = col_q;
        row_d     = row_q;
        bar_cnt_d = bar_cnt_q;
        bar_idx_d = bar_idx_q;
        sx_d      = sx_q;
        sy_d      = sy_q;
        dx_d      = dx_q;
        dy_d      = dy_q;
        mode_d    = mode_q;
        de_d      = de_q;
        hs_d      = hs_q;
        vs_d      = vs_q;
        sof_d     = sof_q;
        pix_d     = pix_q;
        if (vid.ce_i) begin
            de_d  = active;
            hs_d  = ((col_q >= HsBeg) && (col_q < HsEnd)) ? SyncActive : ~SyncActive;
            vs_d  = ((row_q >= VsBeg) && (row_q < VsEnd)) ? SyncActive : ~SyncActive;
            sof_d = (col_q == '0) && (row_q == '0);
            pix_d = active ? pix_rgb : '0;
            if (col_wrap) begin
                col_d     = '0;
                bar_cnt_d = '0;
                bar_idx_d = '0;
                row_d     = (row_q == RowLast) ? cnt_t'(0) : row_q + cnt_t'(1);
            end else begin
                col_d = col_q + cnt_t'(1);
                if (bar_cnt_q == BarLast) begin
                    bar_cnt_d = '0;
                    if (bar_idx_q != 3'd7) bar_idx_d = bar_idx_q + 3'd1;
                end else begin
                    bar_cnt_d = bar_cnt_q + cnt_t'(1);
                end
            end
            // Sprite and mode commit with the frame wrap so the next frame starts consistent.
            if (frame_end) begin
                {dx_d, sx_d} = bounce(sx_q, dx_q, XMax);
                {dy_d, sy_d} = bounce(sy_q, dy_q, YMax);
                mode_d       = vid.mode_i;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            col_q     <= '0;
            row_q     <= '0;
            bar_cnt_q <= '0;
            bar_idx_q <= '0;
            sx_q      <= '0;
            sy_q      <= '0;
            dx_q      <= 1'b0;
            dy_q      <= 1'b0;
            mode_q    <= 2'd0;
            de_q      <= 1'b0;
            hs_q      <= ~SyncActive;
            vs_q      <= ~SyncActive;
            sof_q     <= 1'b0;
            pix_q     <= '0;
        end else begin
            col_q     <= col_d;
            row_q     <= row_d;
            bar_cnt_q <= bar_cnt_d;
            bar_idx_q <= bar_idx_d;
            sx_q      <= sx_d;
            sy_q      <= sy_d;
            dx_q      <= dx_d;
            dy_q      <= dy_d;
            mode_q    <= mode_d;
            de_q      <= de_d;
            hs_q      <= hs_d;
            vs_q      <= vs_d;
            sof_q     <= sof_d;
            pix_q     <= pix_d;
        end
    end

    assign vid.de_o    = de_q;
    assign vid.hsync_o = hs_q;
    assign vid.vsync_o = vs_q;
    assign vid.sof_o   = sof_q;
    assign vid.pix_o   = pix_q;
endmodule
